// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use stall FSM with configurable latency, branch flush and profiling counters.
module hazard_forward_ctrl #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd_exmem,
  input  logic [REG_AW-1:0] rd_memwb,
  input  logic [1:0]        op_type_mem,
  input  logic [3:0]        op_code_mem,
  input  logic [1:0]        op_type_wb,
  input  logic [3:0]        op_code_wb,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  output logic              fa,
  output logic              fb,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {IDLE, LD_WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         lcnt_q, lcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic wr_mem, wr_wb, ld_mem;
  logic hit_m_a, hit_m_b, hit_w_a, hit_w_b;
  logic hazard;

  always_comb begin
    wr_mem = !op_type_mem[1] || (op_type_mem == 2'b10 && op_code_mem == 4'h0);
    wr_wb  = !op_type_wb[1]  || (op_type_wb  == 2'b10 && op_code_wb  == 4'h0);
    ld_mem = (op_type_mem == 2'b10) && (op_code_mem == 4'h0);

    hit_m_a = wr_mem && (ra == rd_exmem) && !(ZERO_REG && ra == '0);
    hit_m_b = wr_mem && (rb == rd_exmem) && !(ZERO_REG && rb == '0);
    hit_w_a = wr_wb  && (ra == rd_memwb) && !(ZERO_REG && ra == '0);
    hit_w_b = wr_wb  && (rb == rd_memwb) && !(ZERO_REG && rb == '0);

    fa    = hit_m_a || hit_w_a;
    fb    = hit_m_b || hit_w_b;
    fwd_a = hit_m_a ? alu_result : wb_result;
    fwd_b = hit_m_b ? alu_result : wb_result;

    hazard = ld_mem && (hit_m_a || hit_m_b);
  end

  // stall/flush are combinational so the hazard is held in the very cycle it is seen;
  // rst_n gating keeps them low for the whole reset window.
  always_comb begin
    stall       = rst_n && !branch_taken && ((state_q == LD_WAIT) || hazard);
    flush_ifid  = rst_n && branch_taken;
    flush_idex  = rst_n && branch_taken;
    flush_exmem = rst_n && branch_taken;
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    if (branch_taken) begin
      state_d = IDLE;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hazard && LOAD_LAT > 1) begin
            state_d = LD_WAIT;
            lcnt_d  = 4'(LOAD_LAT - 1);
          end
        end
        LD_WAIT: begin
          lcnt_d = lcnt_q - 4'd1;
          if (lcnt_q == 4'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && stall_cnt_q != '1)        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (branch_taken && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a LOAD_LAT=3/CNT_W=4 instance plus a
// default-parameter instance sharing the same inputs.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra, rb, rd_exmem, rd_memwb;
  logic [1:0]  op_type_mem, op_type_wb;
  logic [3:0]  op_code_mem, op_code_wb;
  logic [23:0] alu_result, wb_result;
  logic        branch_taken, cnt_clr;

  logic        fa, fb, stall, flush_ifid, flush_idex, flush_exmem;
  logic [23:0] fwd_a, fwd_b;
  logic [3:0]  stall_cnt, flush_cnt;

  logic        fa2, fb2, stall2, fl2_ifid, fl2_idex, fl2_exmem;
  logic [23:0] fwd_a2, fwd_b2;
  logic [15:0] stall_cnt2, flush_cnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.DATA_W(24), .REG_AW(4), .LOAD_LAT(3), .CNT_W(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rd_exmem(rd_exmem), .rd_memwb(rd_memwb),
    .op_type_mem(op_type_mem), .op_code_mem(op_code_mem), .op_type_wb(op_type_wb),
    .op_code_wb(op_code_wb), .alu_result(alu_result), .wb_result(wb_result),
    .branch_taken(branch_taken), .cnt_clr(cnt_clr), .fa(fa), .fb(fb), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_ctrl dut_lat1 (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rd_exmem(rd_exmem), .rd_memwb(rd_memwb),
    .op_type_mem(op_type_mem), .op_code_mem(op_code_mem), .op_type_wb(op_type_wb),
    .op_code_wb(op_code_wb), .alu_result(alu_result), .wb_result(wb_result),
    .branch_taken(branch_taken), .cnt_clr(cnt_clr), .fa(fa2), .fb(fb2), .fwd_a(fwd_a2),
    .fwd_b(fwd_b2), .stall(stall2), .flush_ifid(fl2_ifid), .flush_idex(fl2_idex),
    .flush_exmem(fl2_exmem), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_hazard_b();
    rb = 4'd5; rd_exmem = 4'd5; op_type_mem = 2'b10; op_code_mem = 4'h0;
  endtask

  task automatic clear_mem();
    rb = 4'd0; rd_exmem = 4'd0; op_type_mem = 2'b00; op_code_mem = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; ra = '0; rb = '0; rd_exmem = '0; rd_memwb = '0;
    op_type_mem = 2'b00; op_code_mem = 4'h0; op_type_wb = 2'b00; op_code_wb = 4'h0;
    alu_result = 24'h123456; wb_result = 24'hABCDEF; branch_taken = 1'b0; cnt_clr = 1'b0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_flush", flush_ifid, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // T1: forwarding, EX/MEM priority over MEM/WB
    ra = 4'd3; rd_exmem = 4'd3; rd_memwb = 4'd7; #1;
    check("t1_fa", fa, 1);
    check("t1_fwd_a", fwd_a, 24'h123456);
    check("t1_fb", fb, 0);
    check("t1_fwd_b", fwd_b, 24'hABCDEF);
    rd_memwb = 4'd3; op_type_wb = 2'b01; #1;
    check("t1_prio_fa", fa, 1);
    check("t1_prio_fwd_a", fwd_a, 24'h123456);
    rd_exmem = 4'd9; #1;
    check("t1_wb_fa", fa, 1);
    check("t1_wb_fwd_a", fwd_a, 24'hABCDEF);
    op_type_wb = 2'b11; #1;
    check("t1_nowr_wb", fa, 0);
    op_type_wb = 2'b10; op_code_wb = 4'h0; #1;
    check("t1_ld_wb_fa", fa, 1);
    op_code_wb = 4'h5; #1;
    check("t1_st_wb_fa", fa, 0);
    rb = 4'd9; op_type_mem = 2'b10; op_code_mem = 4'h3; #1;
    check("t1_st_mem_fb", fb, 0);
    op_type_mem = 2'b01; #1;
    check("t1_fb", fb, 1);
    check("t1_fwd_b", fwd_b, 24'h123456);
    check("t1_stall", stall, 0);
    ra = '0; clear_mem(); rd_memwb = '0; op_type_wb = 2'b00; op_code_wb = 4'h0; #1;

    // T2: register 0 never forwarded or stalled on
    op_type_mem = 2'b10; op_code_mem = 4'h0; #1;
    check("t2_fa", fa, 0);
    check("t2_fb", fb, 0);
    check("t2_stall", stall, 0);
    check("t2_stall_l1", stall2, 0);
    clear_mem();

    // T3: one-cycle load-use hazard -> 3 stall cycles (1 for default instance)
    tick();
    set_load_hazard_b(); #1;
    check("t3_stall_c0", stall, 1);
    check("t3_stall_l1_c0", stall2, 1);
    tick(); clear_mem(); #1;
    check("t3_stall_c1", stall, 1);
    check("t3_cnt_c1", stall_cnt, 1);
    check("t3_stall_l1_c1", stall2, 0);
    check("t3_cnt_l1", stall_cnt2, 1);
    tick(); #1;
    check("t3_stall_c2", stall, 1);
    check("t3_cnt_c2", stall_cnt, 2);
    tick(); #1;
    check("t3_stall_c3", stall, 0);
    check("t3_cnt_c3", stall_cnt, 3);
    tick(); #1;
    check("t3_idle", stall, 0);

    // T4: branch in second stall cycle cancels the stall
    set_load_hazard_b(); #1;
    check("t4_stall_c0", stall, 1);
    tick(); clear_mem(); branch_taken = 1'b1; #1;
    check("t4_stall_br", stall, 0);
    check("t4_flush_ifid", flush_ifid, 1);
    check("t4_flush_idex", flush_idex, 1);
    check("t4_flush_exmem", flush_exmem, 1);
    check("t4_fcnt_pre", flush_cnt, 0);
    tick(); branch_taken = 1'b0; #1;
    check("t4_fcnt", flush_cnt, 1);
    check("t4_flush_off", flush_ifid, 0);
    check("t4_stall_after", stall, 0);
    check("t4_scnt", stall_cnt, 4);
    tick(); #1;
    check("t4_idle", stall, 0);

    // T5: sustained stall saturates the 4-bit counter; clear wins
    set_load_hazard_b(); #1;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      check("t5_stall_held", stall, 1);
    end
    check("t5_sat", stall_cnt, 15);
    check("t5_cnt_l1", stall_cnt2, 22);
    clear_mem(); cnt_clr = 1'b1; #1;
    check("t5_tail_stall", stall, 1);
    tick(); cnt_clr = 1'b0; #1;
    check("t5_clr", stall_cnt, 0);
    check("t5_clr_l1", stall_cnt2, 0);
    check("t5_fclr", flush_cnt, 0);
    check("t5_idle", stall, 0);

    // T6: reset mid LD_WAIT aborts stall immediately
    set_load_hazard_b(); #1;
    tick(); clear_mem(); ra = 4'd3; rd_exmem = 4'd3; #1;
    check("t6_stall_pre", stall, 1);
    check("t6_cnt_pre", stall_cnt, 1);
    rst_n = 1'b0; branch_taken = 1'b1; #1;
    check("t6_stall_rst", stall, 0);
    check("t6_cnt_rst", stall_cnt, 0);
    check("t6_flush_rst", flush_ifid, 0);
    check("t6_fa_rst", fa, 1);
    check("t6_fwd_a_rst", fwd_a, 24'h123456);
    branch_taken = 1'b0;
    tick(); #1;
    check("t6_stall_hold", stall, 0);
    rst_n = 1'b1; #1;
    check("t6_stall_rel", stall, 0);
    tick(); #1;
    check("t6_no_residual", stall, 0);
    check("t6_cnt_after", stall_cnt, 0);
    check("t6_fcnt_after", flush_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
